// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter.
// Both ports share one interface instance.
//
//   req0/req1   : access request, held with a stable address until the ack
//   addr0/addr1 : ROM address for the request
//   ack0/ack1   : one-cycle completion pulse; rdataN is valid in that cycle
//   rdata0/1    : captured read data, held until the next ack on that port
//
// The master modport is the requester side (CPU fetch on port 0 and
// debug/loader on port 1). The slave modport is the arbiter side.
interface rom_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, addr0, req1, addr1,
    input  ack0, rdata0, ack1, rdata1
  );

  modport slave (
    input  req0, addr0, req1, addr1,
    output ack0, rdata0, ack1, rdata1
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter and sequencer for one single-port program ROM.
// The ROM has a registered read and a gated output.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   bus        : requester interface (req/addr in, ack/rdata out, two ports)
//   busy       : high whenever an access is in flight (any non-IDLE state)
//   grant      : port being served; shows the last served port while idle
//   rom_addr   : registered ROM address, held after the access
//   rom_enable : ROM output enable. It is low when idle, so the ROM output
//                can be OR-combined with other memories on a shared bus.
//   rom_data   : ROM data output
//
// Sequence per access: IDLE (grant edge) -> WAIT for LATENCY cycles -> CAPT ->
// DONE (ack cycle) -> IDLE. This gives one access every LATENCY+3 cycles.
module rom_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  rom_arbiter_if.slave      bus,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_en_q, rom_en_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              winner;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = rom_en_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    // On a tie the port that was not served last wins. Otherwise the only
    // requester wins.
    winner     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d    = winner;
          rom_addr_d = winner ? bus.addr1 : bus.addr0;
          rom_en_d   = 1'b1;
          cnt_d      = CNT_W'(LATENCY);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        // The ROM output is still enabled during this cycle. Sample it, then
        // release the bus.
        if (grant_q) begin
          rdata1_d = rom_data;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = rom_data;
          ack0_d   = 1'b1;
        end
        last_d   = grant_q;
        rom_en_d = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= 1'b1;
      last_q     <= 1'b1;
      busy_q     <= 1'b0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign busy       = busy_q;
  assign grant      = grant_q;
  assign rom_addr   = rom_addr_q;
  assign rom_enable = rom_en_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter. Instance 0 uses LATENCY=1 and instance 1 uses
// LATENCY=3. Each instance has its own ROM model (registered read with extra
// pipeline stages, and the output gated by rom_enable). A transaction-timing
// model predicts every output on every cycle. Directed tests add literal
// expectations on top of the model.
module tb_rom_arbiter;

  localparam int LAT [2] = '{1, 3};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bif1 ();
  rom_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bif3 ();

  logic       d_busy [2], d_grant [2], d_en [2], d_ack0 [2], d_ack1 [2];
  logic [6:0] d_raddr [2];
  logic [7:0] d_rd0 [2], d_rd1 [2], rom_d [2];
  logic       r0 [2], r1 [2];
  logic [6:0] a0 [2], a1 [2];

  rom_arbiter #(.ADDR_W(7), .DATA_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bif1), .busy(d_busy[0]), .grant(d_grant[0]),
    .rom_addr(d_raddr[0]), .rom_enable(d_en[0]), .rom_data(rom_d[0])
  );
  rom_arbiter #(.ADDR_W(7), .DATA_W(8), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bif3), .busy(d_busy[1]), .grant(d_grant[1]),
    .rom_addr(d_raddr[1]), .rom_enable(d_en[1]), .rom_data(rom_d[1])
  );

  assign r0[0] = bif1.req0;  assign r1[0] = bif1.req1;
  assign a0[0] = bif1.addr0; assign a1[0] = bif1.addr1;
  assign r0[1] = bif3.req0;  assign r1[1] = bif3.req1;
  assign a0[1] = bif3.addr0; assign a1[1] = bif3.addr1;
  assign d_ack0[0] = bif1.ack0; assign d_ack1[0] = bif1.ack1;
  assign d_rd0[0]  = bif1.rdata0; assign d_rd1[0] = bif1.rdata1;
  assign d_ack0[1] = bif3.ack0; assign d_ack1[1] = bif3.ack1;
  assign d_rd0[1]  = bif3.rdata0; assign d_rd1[1] = bif3.rdata1;

  // ROM contents and the two ROM timing models
  logic [7:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[7'h00] = 8'h41; mem[7'h01] = 8'h53; mem[7'h73] = 8'h02;
    mem[7'h7F] = 8'h00; mem[7'h1E] = 8'hAC; mem[7'h08] = 8'h10;
  end
  logic [7:0] rq1, s1, s2, s3;
  always @(posedge clk) begin
    rq1 <= mem[d_raddr[0]];
    s1  <= mem[d_raddr[1]];
    s2  <= s1;
    s3  <= s2;
  end
  assign rom_d[0] = d_en[0] ? rq1 : 8'h00;
  assign rom_d[1] = d_en[1] ? s3  : 8'h00;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [L=%0d] got %0h expected %0h at %0t", name, LAT[n], act, exp, $time);
    end
  endtask

  // Transaction-timing model. The state is the edge count since the grant
  // edge: outputs follow from k (enable while k<=L, ack at k==L+1, idle again
  // at k==L+2). The expected data comes straight from the ROM contents.
  bit         m_idle [2];
  int         m_k [2];
  logic       m_srv [2], m_last [2];
  logic [6:0] m_addr [2];
  logic [7:0] e_rd0 [2], e_rd1 [2];

  function automatic logic pick(input logic q0, input logic q1, input logic last);
    return (q0 && q1) ? !last : q1;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int n = 0; n < 2; n++) begin
      if (!reset) begin
        m_idle[n] <= 1'b1; m_k[n] <= 0; m_srv[n] <= 1'b1; m_last[n] <= 1'b1;
        m_addr[n] <= '0; e_rd0[n] <= '0; e_rd1[n] <= '0;
      end else if (m_idle[n]) begin
        if (r0[n] || r1[n]) begin
          m_srv[n]  <= pick(r0[n], r1[n], m_last[n]);
          m_addr[n] <= pick(r0[n], r1[n], m_last[n]) ? a1[n] : a0[n];
          m_k[n]    <= 0;
          m_idle[n] <= 1'b0;
        end
      end else begin
        m_k[n] <= m_k[n] + 1;
        if (m_k[n] + 1 == LAT[n] + 1) begin
          if (m_srv[n]) e_rd1[n] <= mem[m_addr[n]];
          else          e_rd0[n] <= mem[m_addr[n]];
          m_last[n] <= m_srv[n];
        end
        if (m_k[n] + 1 == LAT[n] + 2) m_idle[n] <= 1'b1;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        chk("busy",     n, d_busy[n],  !m_idle[n]);
        chk("grant",    n, d_grant[n], m_srv[n]);
        chk("rom_en",   n, d_en[n],    !m_idle[n] && m_k[n] <= LAT[n]);
        chk("rom_addr", n, d_raddr[n], m_addr[n]);
        chk("ack0",     n, d_ack0[n],  !m_idle[n] && m_k[n] == LAT[n] + 1 && !m_srv[n]);
        chk("ack1",     n, d_ack1[n],  !m_idle[n] && m_k[n] == LAT[n] + 1 && m_srv[n]);
        chk("rdata0",   n, d_rd0[n],   e_rd0[n]);
        chk("rdata1",   n, d_rd1[n],   e_rd1[n]);
      end
    end
  end

  // Event monitor feeding the literal expectations
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int g_cyc [2], a_cyc [2], en_cnt [2], n_ack0 [2], n_ack1 [2];
  logic pb [2];
  int log_q [$];   // instance 0 acks: port*256 + data
  initial for (int n = 0; n < 2; n++) begin
    g_cyc[n] = 0; a_cyc[n] = 0; en_cnt[n] = 0; n_ack0[n] = 0; n_ack1[n] = 0; pb[n] = 1'b0;
  end
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (d_busy[n] === 1'b1 && pb[n] !== 1'b1) begin
        g_cyc[n]  <= cyc;
        en_cnt[n] <= (d_en[n] === 1'b1) ? 1 : 0;
      end else if (d_en[n] === 1'b1) begin
        en_cnt[n] <= en_cnt[n] + 1;
      end
      if (d_ack0[n] === 1'b1) begin a_cyc[n] <= cyc; n_ack0[n] <= n_ack0[n] + 1; end
      if (d_ack1[n] === 1'b1) begin a_cyc[n] <= cyc; n_ack1[n] <= n_ack1[n] + 1; end
      pb[n] <= d_busy[n];
    end
    if (d_ack0[0] === 1'b1) log_q.push_back(int'(d_rd0[0]));
    if (d_ack1[0] === 1'b1) log_q.push_back(256 + int'(d_rd1[0]));
  end

  // Wait for an ack on port p of instance n, then return right after the
  // edge that ends the ack cycle (where the requester drops req)
  task automatic wait_ack(input int n, input int p, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if ((p == 0 && d_ack0[n] === 1'b1) || (p == 1 && d_ack1[n] === 1'b1)) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout [L=%0d] port %0d: no ack within %0d cycles", LAT[n], p, maxc);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;
    reset = 1'b0;
    bif1.req0 = 0; bif1.req1 = 0; bif1.addr0 = '0; bif1.addr1 = '0;
    bif3.req0 = 0; bif3.req1 = 0; bif3.addr0 = '0; bif3.addr1 = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk); chk_en = 1'b1;

    // Reset state literals
    chk("rst_busy", 0, d_busy[0], 1'b0);
    chk("rst_grant", 0, d_grant[0], 1'b1);
    chk("rst_en", 0, d_en[0], 1'b0);
    chk("rst_rdata0", 0, d_rd0[0], 8'h00);

    // 1: single port 0 read of address 0x00
    @(posedge clk); #1 bif1.req0 = 1; bif1.addr0 = 7'h00;
    wait_ack(0, 0, 20);
    bif1.req0 = 0;
    repeat (2) @(negedge clk);
    chk("t1_ack_cycle", 0, a_cyc[0] - g_cyc[0] + 1, 3);
    chk("t1_rdata0", 0, d_rd0[0], 8'h41);
    chk("t1_model_rdata0", 0, e_rd0[0], 8'h41);
    chk("t1_en_cycles", 0, en_cnt[0], 2);
    chk("t1_no_ack1", 0, n_ack1[0], 0);

    // 2: tie from reset, port 0 first
    do_reset();
    log_q.delete();
    bif1.req0 = 1; bif1.addr0 = 7'h01; bif1.req1 = 1; bif1.addr1 = 7'h73;
    wait_ack(0, 0, 20);
    bif1.req0 = 0;
    wait_ack(0, 1, 20);
    bif1.req1 = 0;
    repeat (2) @(negedge clk);
    chk("t2_n_acks", 0, log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_first", 0, log_q[0], 32'h053);
      chk("t2_second", 0, log_q[1], 32'h102);
    end

    // 3: both held across four accesses: 0,1,0,1
    log_q.delete();
    bif1.req0 = 1; bif1.addr0 = 7'h00; bif1.req1 = 1; bif1.addr1 = 7'h01;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (d_ack0[0] === 1'b1 || d_ack1[0] === 1'b1) acks++;
    end
    @(posedge clk); #1 bif1.req0 = 0; bif1.req1 = 0;
    repeat (3) @(negedge clk);
    chk("t3_n_acks", 0, log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t3_a0", 0, log_q[0], 32'h041);
      chk("t3_a1", 0, log_q[1], 32'h153);
      chk("t3_a2", 0, log_q[2], 32'h041);
      chk("t3_a3", 0, log_q[3], 32'h153);
    end
    chk("t3_rdata0_kept", 0, d_rd0[0], 8'h41);

    // 4: unpopulated address on port 1, then port 0 at 0x1E
    @(posedge clk); #1 bif1.req1 = 1; bif1.addr1 = 7'h7F;
    wait_ack(0, 1, 20);
    bif1.req1 = 0;
    bif1.req0 = 1; bif1.addr0 = 7'h1E;
    wait_ack(0, 0, 20);
    bif1.req0 = 0;
    repeat (2) @(negedge clk);
    chk("t4_rdata1", 0, d_rd1[0], 8'h00);
    chk("t4_rdata0", 0, d_rd0[0], 8'hAC);

    // 5: reset in WAIT aborts the access
    @(posedge clk); #1 bif1.req0 = 1; bif1.addr0 = 7'h08;
    @(posedge clk);            // grant edge
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", 0, d_busy[0], 1'b0);
    chk("t5_en", 0, d_en[0], 1'b0);
    chk("t5_addr", 0, d_raddr[0], 7'h00);
    chk("t5_grant", 0, d_grant[0], 1'b1);
    chk("t5_rdata0", 0, d_rd0[0], 8'h00);
    chk("t5_ack0", 0, d_ack0[0], 1'b0);
    bif1.req0 = 0;
    acks = n_ack0[0];
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_ack0", 0, n_ack0[0] - acks, 0);
    log_q.delete();
    @(posedge clk); #1 bif1.req0 = 1; bif1.addr0 = 7'h1E; bif1.req1 = 1; bif1.addr1 = 7'h73;
    wait_ack(0, 0, 20);
    bif1.req0 = 0;
    wait_ack(0, 1, 20);
    bif1.req1 = 0;
    repeat (2) @(negedge clk);
    chk("t5_tie_n", 0, log_q.size(), 2);
    if (log_q.size() == 2) chk("t5_tie_first", 0, log_q[0], 32'h0AC);

    // 6: LATENCY=3 instance, port 0 reads 0x08
    @(posedge clk); #1 bif3.req0 = 1; bif3.addr0 = 7'h08;
    wait_ack(1, 0, 30);
    bif3.req0 = 0;
    repeat (2) @(negedge clk);
    chk("t6_ack_cycle", 1, a_cyc[1] - g_cyc[1] + 1, 5);
    chk("t6_rdata0", 1, d_rd0[1], 8'h10);
    chk("t6_en_cycles", 1, en_cnt[1], 4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
